// File: rtl/uart_fifo_core.sv
// uart_fifo_core: memory-mapped UART with TX/RX FIFOs, 16-bit baud divisor,
// optional even/odd parity, 1 or 2 stop bits, sticky W1C error flags and a level IRQ.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   waddr/wdata/wen     write port (CTRL 0x0, STAT 0x4 W1C, DATA 0x8 push, BAUD 0xC)
//   wstrb               byte enables
//   wready              constant 1
//   raddr/ren           read port; rdata/rvalid answer one cycle later
//   i_rx_bit            serial input (pre-synchronised, idle 1)
//   o_tx_bit            serial output (idle 1)
//   o_irq               registered level interrupt
module uart_fifo_core #(
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16,
    parameter logic [15:0] DIV_RST  = 16'd53
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic        wen,
    input  logic [3:0]  wstrb,
    output logic        wready,
    input  logic [31:0] raddr,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        i_rx_bit,
    output logic        o_tx_bit,
    output logic        o_irq
);

    localparam int unsigned TxAw = $clog2(TX_DEPTH);
    localparam int unsigned RxAw = $clog2(RX_DEPTH);
    localparam logic [TxAw:0] TxFullCnt = (TxAw + 1)'(TX_DEPTH);
    localparam logic [RxAw:0] RxFullCnt = (RxAw + 1)'(RX_DEPTH);
    localparam logic [TxAw:0] TxCntOne  = (TxAw + 1)'(1);
    localparam logic [RxAw:0] RxCntOne  = (RxAw + 1)'(1);
    localparam logic [TxAw-1:0] TxPtrOne = TxAw'(1);
    localparam logic [RxAw-1:0] RxPtrOne = RxAw'(1);

    localparam logic [31:0] AddrCtrl = 32'h0;
    localparam logic [31:0] AddrStat = 32'h4;
    localparam logic [31:0] AddrData = 32'h8;
    localparam logic [31:0] AddrBaud = 32'hC;

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

    // ---------------------------------------------------------------- registers / decode
    logic [7:0]  ctrl_q, ctrl_d;
    logic [15:0] div_q, div_d;
    logic        tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d;
    logic        par_err_q, par_err_d, frm_err_q, frm_err_d;
    logic        irq_q, irq_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q;

    logic wr_ctrl, wr_stat, wr_data, wr_baud, rd_data;
    logic uart_en, tx_en, rx_en, tx_irq_en, rx_irq_en, par_en, par_odd, stop2;
    logic [7:0] w1c;

    assign wr_ctrl = wen && (waddr == AddrCtrl);
    assign wr_stat = wen && (waddr == AddrStat);
    assign wr_data = wen && (waddr == AddrData);
    assign wr_baud = wen && (waddr == AddrBaud);
    assign rd_data = ren && (raddr == AddrData);

    assign uart_en   = ctrl_q[0];
    assign tx_en     = ctrl_q[1];
    assign rx_en     = ctrl_q[2];
    assign tx_irq_en = ctrl_q[3];
    assign rx_irq_en = ctrl_q[4];
    // 2'b11 is treated as "no parity"
    assign par_en    = (ctrl_q[6:5] == 2'b01) || (ctrl_q[6:5] == 2'b10);
    assign par_odd   = (ctrl_q[6:5] == 2'b10);
    assign stop2     = ctrl_q[7];

    assign w1c = (wr_stat && wstrb[0]) ? wdata[7:0] : 8'h00;

    logic unused_ok;
    assign unused_ok = ^{wdata[31:16], wstrb[3:2]};

    // ---------------------------------------------------------------- baud tick
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic        os_tick;

    // >= rather than == so a smaller DIV written mid-count takes effect at once
    always_comb begin
        os_tick    = 1'b0;
        baud_cnt_d = baud_cnt_q;
        if (!uart_en) begin
            baud_cnt_d = 16'd0;
        end else if (baud_cnt_q >= div_q) begin
            baud_cnt_d = 16'd0;
            os_tick    = 1'b1;
        end else begin
            baud_cnt_d = baud_cnt_q + 16'd1;
        end
    end

    // ---------------------------------------------------------------- TX FIFO
    logic [7:0]      tx_mem_q [TX_DEPTH];
    logic [TxAw-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [TxAw:0]   tx_cnt_q, tx_cnt_d;
    logic            tx_full, tx_empty, tx_push, tx_pop, tx_wr_req, tx_ovf_set;
    logic [7:0]      tx_head;

    assign tx_full    = (tx_cnt_q == TxFullCnt);
    assign tx_empty   = (tx_cnt_q == '0);
    assign tx_head    = tx_mem_q[tx_rptr_q];
    assign tx_wr_req  = wr_data && wstrb[0] && uart_en;
    // A same-cycle pop frees a slot, so a push into a full FIFO is still accepted
    assign tx_push    = tx_wr_req && (!tx_full || tx_pop);
    assign tx_ovf_set = tx_wr_req && tx_full && !tx_pop;

    always_comb begin
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        if (!uart_en) begin
            tx_wptr_d = '0;
            tx_rptr_d = '0;
            tx_cnt_d  = '0;
        end else begin
            if (tx_push) tx_wptr_d = tx_wptr_q + TxPtrOne;
            if (tx_pop)  tx_rptr_d = tx_rptr_q + TxPtrOne;
            if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + TxCntOne;
            else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - TxCntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= wdata[7:0];
    end

    // ---------------------------------------------------------------- TX FSM
    tx_state_e  tx_state_q, tx_state_d;
    logic [3:0] tx_os_q, tx_os_d;
    logic [2:0] tx_idx_q, tx_idx_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       tx_par_q, tx_par_d;
    logic       tx_stop_q, tx_stop_d;  // second stop bit still owed
    logic       tx_busy;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_os_d    = tx_os_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_stop_d  = tx_stop_q;
        tx_pop     = 1'b0;
        if (!uart_en) begin
            tx_state_d = TxIdle;
            tx_os_d    = 4'd0;
        end else if (tx_state_q == TxIdle) begin
            // TX_EN is only looked at here, so clearing it lets the frame finish
            if (tx_en && !tx_empty) begin
                tx_pop     = 1'b1;
                tx_shift_d = tx_head;
                tx_par_d   = (^tx_head) ^ par_odd;
                tx_stop_d  = stop2;
                tx_os_d    = 4'd0;
                tx_idx_d   = 3'd0;
                tx_state_d = TxStart;
            end
        end else if (os_tick) begin
            tx_os_d = tx_os_q + 4'd1;
            if (tx_os_q == 4'd15) begin
                case (tx_state_q)
                    TxStart: tx_state_d = TxData;
                    TxData: begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_idx_d   = tx_idx_q + 3'd1;
                        if (tx_idx_q == 3'd7) tx_state_d = par_en ? TxParity : TxStop;
                    end
                    TxParity: tx_state_d = TxStop;
                    TxStop: begin
                        if (tx_stop_q) tx_stop_d  = 1'b0;
                        else           tx_state_d = TxIdle;
                    end
                    default: tx_state_d = TxIdle;
                endcase
            end
        end
    end

    always_comb begin
        o_tx_bit = 1'b1;
        case (tx_state_q)
            TxStart:  o_tx_bit = 1'b0;
            TxData:   o_tx_bit = tx_shift_q[0];
            TxParity: o_tx_bit = tx_par_q;
            default:  o_tx_bit = 1'b1;
        endcase
        if (!uart_en) o_tx_bit = 1'b1;
    end

    assign tx_busy = (tx_state_q != TxIdle);

    // ---------------------------------------------------------------- RX FIFO
    logic [7:0]      rx_mem_q [RX_DEPTH];
    logic [RxAw-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [RxAw:0]   rx_cnt_q, rx_cnt_d;
    logic            rx_full, rx_empty, rx_push, rx_pop;
    logic [7:0]      rx_head;
    logic [7:0]      rx_shift_q, rx_shift_d;

    assign rx_full  = (rx_cnt_q == RxFullCnt);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_head  = rx_mem_q[rx_rptr_q];
    assign rx_pop   = rd_data && !rx_empty && uart_en;

    always_comb begin
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        if (!uart_en) begin
            rx_wptr_d = '0;
            rx_rptr_d = '0;
            rx_cnt_d  = '0;
        end else begin
            if (rx_push) rx_wptr_d = rx_wptr_q + RxPtrOne;
            if (rx_pop)  rx_rptr_d = rx_rptr_q + RxPtrOne;
            if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + RxCntOne;
            else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - RxCntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem_q[rx_wptr_q] <= rx_shift_q;
    end

    // ---------------------------------------------------------------- RX FSM
    rx_state_e  rx_state_q, rx_state_d;
    logic [3:0] rx_os_q, rx_os_d;
    logic [2:0] rx_idx_q, rx_idx_d;
    logic       rx_prev_q;
    logic       rx_ovr_set, par_err_set, frm_err_set;
    logic       rx_sample, rx_bit_end;

    // os 7 -> 8 transition is the bit centre, os 15 -> 0 ends the bit
    assign rx_sample  = os_tick && (rx_os_q == 4'd7);
    assign rx_bit_end = os_tick && (rx_os_q == 4'd15);

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_os_d     = rx_os_q;
        rx_idx_d    = rx_idx_q;
        rx_shift_d  = rx_shift_q;
        rx_push     = 1'b0;
        rx_ovr_set  = 1'b0;
        par_err_set = 1'b0;
        frm_err_set = 1'b0;
        if (!uart_en) begin
            rx_state_d = RxIdle;
            rx_os_d    = 4'd0;
        end else begin
            if (rx_state_q != RxIdle && os_tick) rx_os_d = rx_os_q + 4'd1;
            case (rx_state_q)
                RxIdle: begin
                    if (rx_en && rx_prev_q && !i_rx_bit) begin
                        rx_os_d    = 4'd0;
                        rx_state_d = RxStart;
                    end
                end
                RxStart: begin
                    if (rx_sample && i_rx_bit) begin
                        rx_state_d = RxIdle;  // glitch, not a start bit
                    end else if (rx_bit_end) begin
                        rx_idx_d   = 3'd0;
                        rx_state_d = RxData;
                    end
                end
                RxData: begin
                    if (rx_sample) rx_shift_d = {i_rx_bit, rx_shift_q[7:1]};
                    if (rx_bit_end) begin
                        rx_idx_d = rx_idx_q + 3'd1;
                        if (rx_idx_q == 3'd7) rx_state_d = par_en ? RxParity : RxStop;
                    end
                end
                RxParity: begin
                    if (rx_sample && (i_rx_bit != ((^rx_shift_q) ^ par_odd))) par_err_set = 1'b1;
                    if (rx_bit_end) rx_state_d = RxStop;
                end
                RxStop: begin
                    // Decide at the centre of the first stop bit so a back-to-back start
                    // edge is not missed; a second stop bit is not checked.
                    if (rx_sample) begin
                        rx_state_d = RxIdle;
                        if (!i_rx_bit)               frm_err_set = 1'b1;
                        else if (rx_full && !rx_pop) rx_ovr_set  = 1'b1;
                        else                         rx_push     = 1'b1;
                    end
                end
                default: rx_state_d = RxIdle;
            endcase
        end
    end

    // ---------------------------------------------------------------- CSR next state
    logic [8:0] stat;

    assign stat = {tx_busy, frm_err_q, par_err_q, rx_ovr_q, tx_ovf_q,
                   rx_full, rx_empty, tx_empty, tx_full};

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_ctrl && wstrb[0]) ctrl_d = wdata[7:0];
        div_d = div_q;
        if (wr_baud && wstrb[0]) div_d[7:0]  = wdata[7:0];
        if (wr_baud && wstrb[1]) div_d[15:8] = wdata[15:8];
        // Set beats a simultaneous write-one-to-clear
        tx_ovf_d  = tx_ovf_set  | (tx_ovf_q  & ~w1c[4]);
        rx_ovr_d  = rx_ovr_set  | (rx_ovr_q  & ~w1c[5]);
        par_err_d = par_err_set | (par_err_q & ~w1c[6]);
        frm_err_d = frm_err_set | (frm_err_q & ~w1c[7]);
        irq_d = uart_en & ((tx_irq_en & tx_empty & ~tx_busy) |
                           (rx_irq_en & (~rx_empty | rx_ovr_q | par_err_q | frm_err_q)));
    end

    always_comb begin
        rdata_d = rdata_q;
        if (ren) begin
            case (raddr)
                AddrCtrl: rdata_d = {24'd0, ctrl_q};
                AddrStat: rdata_d = {23'd0, stat};
                AddrData: rdata_d = rx_empty ? 32'd0 : {24'd0, rx_head};
                AddrBaud: rdata_d = {16'd0, div_q};
                default:  rdata_d = 32'd0;
            endcase
        end
    end

    // ---------------------------------------------------------------- state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= 8'd0;
            div_q      <= DIV_RST;
            tx_ovf_q   <= 1'b0;
            rx_ovr_q   <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            irq_q      <= 1'b0;
            rdata_q    <= 32'd0;
            rvalid_q   <= 1'b0;
            baud_cnt_q <= 16'd0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_cnt_q   <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_cnt_q   <= '0;
            tx_state_q <= TxIdle;
            tx_os_q    <= 4'd0;
            tx_idx_q   <= 3'd0;
            tx_shift_q <= 8'd0;
            tx_par_q   <= 1'b0;
            tx_stop_q  <= 1'b0;
            rx_state_q <= RxIdle;
            rx_os_q    <= 4'd0;
            rx_idx_q   <= 3'd0;
            rx_shift_q <= 8'd0;
            rx_prev_q  <= 1'b1;
        end else begin
            ctrl_q     <= ctrl_d;
            div_q      <= div_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_ovr_q   <= rx_ovr_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= ren;
            baud_cnt_q <= baud_cnt_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_state_q <= tx_state_d;
            tx_os_q    <= tx_os_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_stop_q  <= tx_stop_d;
            rx_state_q <= rx_state_d;
            rx_os_q    <= rx_os_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_prev_q  <= i_rx_bit;
        end
    end

    assign wready = 1'b1;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign o_irq  = irq_q;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: register table plus serial-frame sequences.
module tb_uart_fifo_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] waddr, wdata, raddr, rdata;
    logic        wen, ren, wready, rvalid;
    logic [3:0]  wstrb;
    logic        i_rx_bit, o_tx_bit, o_irq;
    logic        loopback, rx_drv;

    int n_checks = 0;
    int n_fail   = 0;

    assign i_rx_bit = loopback ? o_tx_bit : rx_drv;

    always #5 clk = ~clk;

    uart_fifo_core #(
        .TX_DEPTH(16),
        .RX_DEPTH(16),
        .DIV_RST (16'd53)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .waddr   (waddr),
        .wdata   (wdata),
        .wen     (wen),
        .wstrb   (wstrb),
        .wready  (wready),
        .raddr   (raddr),
        .ren     (ren),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .i_rx_bit(i_rx_bit),
        .o_tx_bit(o_tx_bit),
        .o_irq   (o_irq)
    );

    typedef struct {
        bit          is_rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        waddr = a;
        wdata = d;
        wstrb = s;
        wen   = 1'b1;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        @(negedge clk);
        raddr = a;
        ren   = 1'b1;
        @(negedge clk);
        ren = 1'b0;
        d   = rdata;
        v   = rvalid;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        v;
        bus_read(a, d, v);
        check(name, d, exp);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame on rx_drv at 16 clocks per bit (DIV=0), then one idle bit time.
    task automatic send_frame(input logic [7:0] b, input bit has_par, input bit par_bit,
                              input bit stop_bit);
        rx_drv = 1'b0;
        cycles(16);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            cycles(16);
        end
        if (has_par) begin
            rx_drv = par_bit;
            cycles(16);
        end
        rx_drv = stop_bit;
        cycles(16);
        rx_drv = 1'b1;
        cycles(16);
    endtask

    task automatic wait_tx_low(input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!o_tx_bit) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        v;
        bit          found;
        logic [7:0]  exp_byte;
        logic [7:0]  pat;

        rst = 1'b1; wen = 1'b0; ren = 1'b0; waddr = '0; wdata = '0; wstrb = '0; raddr = '0;
        loopback = 1'b0; rx_drv = 1'b1;

        vecs[0]  = '{1'b1, 32'h0,  32'h0,        4'h0, 32'h0000_0000, "ctrl_rst"};
        vecs[1]  = '{1'b1, 32'h4,  32'h0,        4'h0, 32'h0000_0006, "stat_rst"};
        vecs[2]  = '{1'b1, 32'hC,  32'h0,        4'h0, 32'h0000_0035, "baud_rst"};
        vecs[3]  = '{1'b1, 32'h8,  32'h0,        4'h0, 32'h0000_0000, "data_empty"};
        vecs[4]  = '{1'b1, 32'h10, 32'h0,        4'h0, 32'h0000_0000, "unmapped_rd"};
        vecs[5]  = '{1'b0, 32'h0,  32'h0000_00FF, 4'hF, 32'h0,        "w_ctrl"};
        vecs[6]  = '{1'b1, 32'h0,  32'h0,        4'h0, 32'h0000_00FF, "ctrl_ff"};
        vecs[7]  = '{1'b0, 32'h0,  32'h0000_0000, 4'h0, 32'h0,        "w_ctrl_nostrb"};
        vecs[8]  = '{1'b1, 32'h0,  32'h0,        4'h0, 32'h0000_00FF, "ctrl_nostrb"};
        vecs[9]  = '{1'b0, 32'h0,  32'h0000_0000, 4'h1, 32'h0,        "w_ctrl0"};
        vecs[10] = '{1'b0, 32'hC,  32'h0000_1234, 4'hF, 32'h0,        "w_baud"};
        vecs[11] = '{1'b1, 32'hC,  32'h0,        4'h0, 32'h0000_1234, "baud_rd"};
        vecs[12] = '{1'b0, 32'hC,  32'h0000_AB00, 4'h2, 32'h0,        "w_baud_hi"};
        vecs[13] = '{1'b1, 32'hC,  32'h0,        4'h0, 32'h0000_AB34, "baud_lane"};
        vecs[14] = '{1'b0, 32'h4,  32'h0000_01FF, 4'hF, 32'h0,        "w_stat_ro"};
        vecs[15] = '{1'b1, 32'h4,  32'h0,        4'h0, 32'h0000_0006, "stat_ro"};

        cycles(3);
        rst = 1'b0;
        check("tx_idle_rst", {31'd0, o_tx_bit}, 32'd1);
        check("irq_rst", {31'd0, o_irq}, 32'd0);
        check("rvalid_rst", {31'd0, rvalid}, 32'd0);
        check("rdata_rst", rdata, 32'd0);
        check("wready", {31'd0, wready}, 32'd1);

        foreach (vecs[i]) begin
            if (vecs[i].is_rd) begin
                bus_read(vecs[i].addr, d, v);
                check(vecs[i].name, d, vecs[i].exp);
                check("rvalid", {31'd0, v}, 32'd1);
            end else begin
                bus_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            end
        end
        cycles(1);
        check("rvalid_pulse", {31'd0, rvalid}, 32'd0);

        // TX waveform of 0x55, 8N1, 16 clocks per bit
        reset_dut();
        bus_write(32'hC, 32'd0, 4'hF);
        bus_write(32'h0, 32'h07, 4'hF);
        bus_write(32'h8, 32'h55, 4'hF);
        wait_tx_low(50, found);
        check("tx_start_seen", {31'd0, found}, 32'd1);
        cycles(7);
        check("tx_start_bit", {31'd0, o_tx_bit}, 32'd0);
        read_check("tx_busy_stat", 32'h4, 32'h0000_0106);
        cycles(14);  // the read above consumed 2 cycles
        pat = 8'h55;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tx_bit%0d", i), {31'd0, o_tx_bit}, {31'd0, pat[i]});
            cycles(16);
        end
        check("tx_stop_bit", {31'd0, o_tx_bit}, 32'd1);
        cycles(16);
        read_check("tx_done_stat", 32'h4, 32'h0000_0006);

        // Loopback with even parity
        reset_dut();
        loopback = 1'b1;
        bus_write(32'hC, 32'd0, 4'hF);
        bus_write(32'h0, 32'h27, 4'hF);
        bus_write(32'h8, 32'hA5, 4'hF);
        bus_write(32'h8, 32'h3C, 4'hF);
        cycles(420);
        read_check("lb_byte0", 32'h8, 32'hA5);
        read_check("lb_byte1", 32'h8, 32'h3C);
        read_check("lb_stat", 32'h4, 32'h0000_0006);
        loopback = 1'b0;

        // TX FIFO overflow with TX_EN=0, W1C, flush on disable, TX irq
        reset_dut();
        bus_write(32'h0, 32'h01, 4'hF);
        for (int i = 0; i < 17; i++) bus_write(32'h8, 32'(i), 4'h1);
        read_check("txovf_stat", 32'h4, 32'h0000_0015);
        bus_write(32'h4, 32'h10, 4'h1);
        read_check("txovf_w1c", 32'h4, 32'h0000_0005);
        bus_write(32'h0, 32'h00, 4'hF);
        read_check("flush_stat", 32'h4, 32'h0000_0006);
        bus_write(32'h0, 32'h09, 4'hF);
        cycles(2);
        check("tx_irq", {31'd0, o_irq}, 32'd1);

        // RX FIFO overrun: 17 frames, none read
        reset_dut();
        bus_write(32'hC, 32'd0, 4'hF);
        bus_write(32'h0, 32'h05, 4'hF);
        for (int i = 0; i < 17; i++) send_frame(8'(i * 37 + 5), 1'b0, 1'b0, 1'b1);
        read_check("rxovr_stat", 32'h4, 32'h0000_002A);
        for (int i = 0; i < 16; i++) begin
            exp_byte = 8'(i * 37 + 5);
            read_check($sformatf("rx_byte%0d", i), 32'h8, {24'd0, exp_byte});
        end
        read_check("rx_drained", 32'h4, 32'h0000_0026);

        // Framing error with RX irq
        reset_dut();
        bus_write(32'hC, 32'd0, 4'hF);
        bus_write(32'h0, 32'h15, 4'hF);
        cycles(2);
        check("irq_quiet", {31'd0, o_irq}, 32'd0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        read_check("frm_stat", 32'h4, 32'h0000_0086);
        check("frm_irq", {31'd0, o_irq}, 32'd1);
        bus_write(32'h4, 32'h80, 4'h1);
        cycles(2);
        check("frm_irq_clr", {31'd0, o_irq}, 32'd0);

        // Parity error still pushes the byte; good parity afterwards
        reset_dut();
        bus_write(32'hC, 32'd0, 4'hF);
        bus_write(32'h0, 32'h25, 4'hF);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
        read_check("par_stat", 32'h4, 32'h0000_0042);
        read_check("par_byte", 32'h8, 32'h5A);
        bus_write(32'h4, 32'h40, 4'h1);
        send_frame(8'h5B, 1'b1, 1'b1, 1'b1);
        read_check("par_ok_stat", 32'h4, 32'h0000_0002);
        read_check("par_ok_byte", 32'h8, 32'h5B);

        // Reset mid-frame
        reset_dut();
        bus_write(32'hC, 32'd0, 4'hF);
        bus_write(32'h0, 32'h07, 4'hF);
        bus_write(32'h8, 32'h00, 4'hF);
        wait_tx_low(50, found);
        check("rst_frame_seen", {31'd0, found}, 32'd1);
        cycles(20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_tx_idle", {31'd0, o_tx_bit}, 32'd1);
        read_check("rst_stat", 32'h4, 32'h0000_0006);
        read_check("rst_ctrl", 32'h0, 32'h0000_0000);
        read_check("rst_baud", 32'hC, 32'h0000_0035);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
